cam_capture_ctrl: RTL and testbench

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

---
 rtl/cam_pkg.sv | 17 +
 rtl/cam_capture_ctrl_if.sv | 27 ++
 rtl/cam_byte_pack.sv | 44 ++++
 rtl/cam_capture_ctrl.sv | 145 ++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture controller.
// Holds the FSM state enum, bus widths and default frame dimensions.
package cam_pkg;

    localparam int unsigned ADDR_W      = 17;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned H_PIX_DEF   = 320;
    localparam int unsigned V_LINES_DEF = 240;

    typedef enum logic [1:0] {
        StIdle,
        StWaitVs,
        StCapture,
        StDone
    } state_e;

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera-side inputs and frame-buffer write port of cam_capture_ctrl.
// The master modport drives the camera side; the slave modport is the controller.
interface cam_capture_ctrl_if;
    import cam_pkg::*;

    logic              start;
    logic              vsync;
    logic              href;
    logic [7:0]        px_data;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic              regwrite;
    logic              busy;
    logic              frame_done;
    logic              err_short;

    modport master (
        output start, vsync, href, px_data,
        input  addr_in, data_in, regwrite, busy, frame_done, err_short
    );

    modport slave (
        input  start, vsync, href, px_data,
        output addr_in, data_in, regwrite, busy, frame_done, err_short
    );

endinterface

// File: rtl/cam_byte_pack.sv
// Pairs camera bytes into 16-bit pixels, high byte first.
// pix_valid_o flags the cycle in which the low byte completes a pixel.
module cam_byte_pack
    import cam_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [7:0]        byte_i,
    output logic              pix_valid_o,
    output logic [DATA_W-1:0] pix_o
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clear_i) begin
            phase_d = 1'b0;
        end else if (en_i) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = byte_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    assign pix_valid_o = en_i & phase_q & ~clear_i;
    assign pix_o       = {hi_q, byte_i};

endmodule

// File: rtl/cam_capture_ctrl.sv
// Captures one camera frame into a linear pixel buffer, one write per pixel.
// Define CAM_CONTINUOUS_EN to re-arm automatically after each frame.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned H_PIX   = H_PIX_DEF,
    parameter int unsigned V_LINES = V_LINES_DEF
) (
    input logic               clk,
    input logic               rst,
    cam_capture_ctrl_if.slave bus
);

    // One extra bit so the address can reach H_PIX*V_LINES == 2^17 without wrapping.
    localparam int unsigned     CntW     = ADDR_W + 1;
    localparam logic [CntW-1:0] TotalPix = CntW'(H_PIX * V_LINES);
    localparam logic [CntW-1:0] HPix     = CntW'(H_PIX);
    localparam logic [CntW-1:0] VLines   = CntW'(V_LINES);

    state_e            state_q, state_d;
    logic [CntW-1:0]   addr_q, addr_d;
    logic [CntW-1:0]   row_q, row_d;
    logic [CntW-1:0]   col_q, col_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              vsync_q, href_q;

    logic              pk_clear, pk_en, pix_valid;
    logic [DATA_W-1:0] pix;
    logic              vs_fall, vs_rise, href_fall;

    assign vs_fall   = vsync_q & ~bus.vsync;
    assign vs_rise   = ~vsync_q & bus.vsync;
    assign href_fall = href_q & ~bus.href;

    cam_byte_pack u_byte_pack (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (pk_clear),
        .en_i       (pk_en),
        .byte_i     (bus.px_data),
        .pix_valid_o(pix_valid),
        .pix_o      (pix)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        row_d    = row_q;
        col_d    = col_q;
        err_d    = err_q;
        wr_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        pk_clear = 1'b0;
        pk_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StWaitVs;
                    err_d   = 1'b0;
                end
            end
            StWaitVs: begin
                if (vs_fall) begin
                    state_d  = StCapture;
                    addr_d   = '0;
                    row_d    = '0;
                    col_d    = '0;
                    pk_clear = 1'b1;
                end
            end
            StCapture: begin
                // Frame end takes priority: a byte arriving with the vsync rise is dropped.
                if (vs_rise || (addr_q == TotalPix)) begin
                    state_d = StDone;
                    err_d   = err_q | (addr_q < TotalPix);
                end else if (bus.href) begin
                    pk_en = 1'b1;
                    if (pix_valid) begin
                        col_d = col_q + 1'b1;
                        if ((col_q < HPix) && (row_q < VLines) && (addr_q < TotalPix)) begin
                            wr_d    = 1'b1;
                            waddr_d = addr_q[ADDR_W-1:0];
                            wdata_d = pix;
                            addr_d  = addr_q + 1'b1;
                        end
                    end
                end else if (href_fall) begin
                    row_d    = row_q + 1'b1;
                    col_d    = '0;
                    pk_clear = 1'b1;
                end
            end
            StDone: begin
`ifdef CAM_CONTINUOUS_EN
                state_d = StWaitVs;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            vsync_q <= bus.vsync;
            href_q  <= bus.href;
        end
    end

    assign bus.addr_in    = waddr_q;
    assign bus.data_in    = wdata_q;
    assign bus.regwrite   = wr_q;
    assign bus.frame_done = (state_q == StDone);
    assign bus.err_short  = err_q;
`ifdef CAM_CONTINUOUS_EN
    assign bus.busy = (state_q != StIdle);
`else
    assign bus.busy = (state_q == StWaitVs) || (state_q == StCapture);
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl with H_PIX=4, V_LINES=2 and random frames.
// Works in both builds; CAM_CONTINUOUS_EN switches the expected DONE exit.
module tb_cam_capture_ctrl;
    import cam_pkg::*;

    localparam int unsigned HP  = 4;
    localparam int unsigned VL  = 2;
    localparam int unsigned TOT = HP * VL;
`ifdef CAM_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cam_capture_ctrl_if bus ();

    cam_capture_ctrl #(
        .H_PIX  (HP),
        .V_LINES(VL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    wr_t  wq[$];
    bit   fq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   line_len[8];
    int   n_lines;
    bit   seq;
    logic [7:0] seq_b;
    bit   sticky_err = 1'b0;
    bit   dut_idle   = 1'b1;
    bit   chk_busy   = 1'b0;
    int   busy_drops = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every write and frame_done pulse is matched against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.regwrite) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                             bus.addr_in, bus.data_in);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wr_addr", 32'(bus.addr_in), 32'(w.a));
                    check("wr_data", 32'(bus.data_in), 32'(w.d));
                end
            end
            if (bus.frame_done) begin
                if (fq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got 1, expected 0");
                end else begin
                    bit e;
                    e = fq.pop_front();
                    check("err_short_at_done", 32'(bus.err_short), 32'(e));
                end
            end
            if (chk_busy && !bus.busy) busy_drops++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit tail, input bit start_in_gaps);
        logic [7:0] bytes[8][16];
        int cum[8];
        int waddr;
        int keep;
        bit e;
        int t;
        for (int li = 0; li < n_lines; li++) begin
            for (int bi = 0; bi < line_len[li]; bi++) begin
                if (seq) begin
                    bytes[li][bi] = seq_b;
                    seq_b++;
                end else begin
                    bytes[li][bi] = 8'($urandom);
                end
            end
        end
        // Reference: each line yields floor(bytes/2) pixels, first HP kept, first VL lines,
        // packed linearly and capped at the frame size.
        waddr = 0;
        for (int li = 0; li < n_lines; li++) begin
            keep = (li < VL) ? ((line_len[li] / 2 < HP) ? line_len[li] / 2 : HP) : 0;
            if (keep > TOT - waddr) keep = TOT - waddr;
            for (int p = 0; p < keep; p++) begin
                wq.push_back('{a: ADDR_W'(waddr + p),
                               d: {bytes[li][2*p], bytes[li][2*p+1]}});
            end
            waddr += keep;
            cum[li] = waddr;
        end
        if (dut_idle) sticky_err = 1'b0;
        e = sticky_err | (waddr < TOT);
        sticky_err = e;
        fq.push_back(e);

        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        dut_idle = 1'b0;
        repeat (2) cyc();
        bus.vsync = 1'b0;
        cyc();
        for (int li = 0; li < n_lines; li++) begin
            for (int bi = 0; bi < line_len[li]; bi++) begin
                bus.href    = 1'b1;
                bus.px_data = bytes[li][bi];
                cyc();
            end
            bus.href    = 1'b0;
            bus.px_data = 8'($urandom);
            for (int g = 0; g < 1 + int'($urandom_range(2)); g++) begin
                bus.start = start_in_gaps && (g == 0) && (cum[li] < TOT);
                cyc();
                bus.start = 1'b0;
            end
        end
        bus.vsync = 1'b1;
        if (tail) begin
            bus.href    = 1'b1;
            bus.px_data = 8'($urandom);
        end
        cyc();
        bus.href = 1'b0;
        t = 0;
        while ((wq.size() != 0 || fq.size() != 0) && t < 30) begin
            cyc();
            t++;
        end
        check("frame_drained", 32'(wq.size() + fq.size()), 32'd0);
        repeat (3) cyc();
        check("busy_after_frame", 32'(bus.busy), 32'(CONT));
        check("err_short_sticky", 32'(bus.err_short), 32'(sticky_err));
        dut_idle = !CONT;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.vsync   = 1'b1;
        bus.href    = 1'b0;
        bus.px_data = 8'h00;
        repeat (3) cyc();
        check("rst_regwrite", 32'(bus.regwrite), 32'd0);
        check("rst_addr", 32'(bus.addr_in), 32'd0);
        check("rst_data", 32'(bus.data_in), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_err_short", 32'(bus.err_short), 32'd0);
        rst = 1'b1;
        repeat (2) cyc();

        // Nominal frame, bytes 0x01..0x10.
        n_lines = 2; line_len[0] = 8; line_len[1] = 8; seq = 1'b1; seq_b = 8'h01;
        run_frame(1'b0, 1'b0);
        seq = 1'b0;
        chk_busy = CONT;

        // Overlong first line.
        n_lines = 2; line_len[0] = 12; line_len[1] = 8;
        run_frame(1'b0, 1'b0);

        // Short frame: three pixels then vsync.
        n_lines = 1; line_len[0] = 6;
        run_frame(1'b0, 1'b0);

        // Start pulses during capture, plus a byte coinciding with the vsync rise.
        n_lines = 2; line_len[0] = 8; line_len[1] = 8;
        run_frame(1'b1, 1'b1);

        // Reset after two writes of a frame in progress.
        chk_busy = 1'b0;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (2) cyc();
        bus.vsync = 1'b0;
        cyc();
        for (int p = 0; p < 2; p++) begin
            logic [7:0] hi;
            logic [7:0] lo;
            hi = 8'($urandom);
            lo = 8'($urandom);
            wq.push_back('{a: ADDR_W'(p), d: {hi, lo}});
            bus.href = 1'b1;
            bus.px_data = hi;
            cyc();
            bus.px_data = lo;
            cyc();
        end
        bus.href = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check("midrst_writes_seen", 32'(wq.size()), 32'd0);
        check("midrst_regwrite", 32'(bus.regwrite), 32'd0);
        check("midrst_addr", 32'(bus.addr_in), 32'd0);
        check("midrst_data", 32'(bus.data_in), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_frame_done", 32'(bus.frame_done), 32'd0);
        check("midrst_err_short", 32'(bus.err_short), 32'd0);
        rst = 1'b1;
        bus.vsync = 1'b1;
        sticky_err = 1'b0;
        dut_idle = 1'b1;
        repeat (2) cyc();

        // New frame after reset starts again at address 0.
        n_lines = 2; line_len[0] = 8; line_len[1] = 8;
        run_frame(1'b0, 1'b0);
        chk_busy = CONT;

        for (int f = 0; f < 12; f++) begin
            n_lines = 1 + int'($urandom_range(3));
            for (int li = 0; li < n_lines; li++) line_len[li] = 1 + int'($urandom_range(11));
            run_frame(1'($urandom), 1'($urandom));
        end

`ifdef CAM_CONTINUOUS_EN
        check("busy_held_continuous", 32'(busy_drops), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, expected $finish");
        $fatal(1, "timeout");
    end

endmodule
